gate_identifier: RTL and testbench
==================================

// Module: gate_identifier
// PURPOSE
//  Identifies an unknown 2-input gate. The block drives the gate's two inputs,
//  reads back its single output, and classifies the gate as one of the 8 gate-block functions.
//  Sits in the Calculator bench/board path as the stimulus+observer end of the gate block.
//  Sweeps all 4 input vectors, captures the truth table, decodes it, and presents the result over a valid/ready handshake.
// PARAMETERS
//  SETTLE_CYCLES  4  clocks each vector is held before dut_y is sampled; legal range 1..255
//  SYNC_STAGES    2  flops in the dut_y synchronizer; SETTLE_CYCLES must be >= SYNC_STAGES+1
// PORTS
//  clk          in   1  system clock, rising edge
//  rst_n        in   1  asynchronous active-low reset
//  start        in   1  level-sampled request; acted on only in IDLE
//  busy         out  1  high in DRIVE and DECIDE
//  drv_in1      out  1  drives gate input in1
//  drv_in2      out  1  drives gate input in2
//  dut_y        in   1  gate output under test; asynchronous to clk
//  res_valid    out  1  result available
//  res_ready    in   1  consumer accepts result
//  res_code     out  3  0=AND 1=OR 2=XOR 3=NAND 4=NOR 5=XNOR 6=NOT(in1) 7=BUF(in1)
//  res_unknown  out  1  truth table matches no code; res_code then 0
//  res_tt       out  4  captured truth table; bit k = output for {in1,in2}=k
// BEHAVIOUR
//  Reset (async, rst_n=0): state IDLE; all outputs 0, including drv_*; tt, vector index and counter cleared.
//    Synchronizer flops are cleared.
//  FSM states: IDLE -> DRIVE -> DECIDE -> DONE -> IDLE.
//  IDLE: drv_*=00. start=1 at an edge -> DRIVE with k=0, cnt=0.
//  DRIVE:
//    - {drv_in1,drv_in2}=k (registered). cnt increments every clock.
//    - At the edge where cnt==SETTLE_CYCLES-1: tt[k] <= dut_y_sync and cnt <= 0.
//    - If k<3 at that edge, k <= k+1; if k==3, next state is DECIDE.
//  DECIDE:
//    - One cycle. drv_* return to 00.
//    - At the edge that leaves DECIDE, res_tt, res_code, res_unknown and res_valid=1 are registered.
//    - Next state is DONE.
//  Decode table (res_tt -> code): 1000->0, 1110->1, 0110->2, 0111->3, 0001->4, 1001->5, 0011->6, 1100->7.
//    Any other value -> res_unknown=1, code 0.
//  DONE:
//    - Result outputs are stable while res_valid=1.
//    - On an edge with res_valid&res_ready: res_valid <= 0 and state <= IDLE.
//    - res_code, res_tt and res_unknown keep their values until the next DECIDE.
//  Latency: start accepted at edge E0 -> res_valid high after edge E0+4*SETTLE_CYCLES+1.
//    With defaults this is 17 clocks.
//  start while busy or in DONE: ignored; no queuing.
//  start held high continuously: a new sweep begins on the edge after the handshake completes.
//    That edge is the first IDLE edge.
//  res_ready high before res_valid: has no effect; the handshake completes on the first edge where both are high.
//  Reset mid-sweep: sweep is abandoned, outputs go to the reset values immediately, and no partial result is reported.
//  cnt width: $clog2(SETTLE_CYCLES+1). k is 2 bits and never wraps past 3 within a sweep.
// STRUCTURE
//  Shared package calc_pkg:
//    - GATE_AND..GATE_BUF 3-bit code constants.
//    - TT_AND..TT_BUF 4-bit truth-table constants.
//    - gate_state_t enum (IDLE, DRIVE, DECIDE, DONE).
//  Sub-module sync_ff (param STAGES): resettable bit synchronizer for dut_y.
//  FSM, counter, tt register and decode all sit in gate_identifier. Decode is a case on res_tt built from the package constants.
// TESTING
//  Bench: a behavioural gate model answers dut_y from drv_* with a 1-cycle delay. It is selectable per test.
//  1. XOR model, SETTLE=4, start pulse -> drv sequence 00,01,10,11, 4 clocks each.
//     res_valid at cycle 17, res_tt=0110, res_code=2, res_unknown=0.
//  2. Sweep each of the 8 gate-block functions in turn -> res_code 0..7, with res_tt exactly per the decode table.
//  3. Constant-1 model -> res_tt=1111, res_unknown=1, res_code=0.
//     in2-only buffer -> res_tt=1010, res_unknown=1.
//  4. NAND model, res_ready held 0 for 10 cycles after res_valid -> res_* stable throughout.
//     Raise res_ready -> res_valid drops the next edge. start pulses during DRIVE and DONE are ignored.
//  5. rst_n low at cycle 9 of a sweep -> all outputs 0 asynchronously.
//     Release and start again with the AND model -> clean result, code 0, at 17 cycles.
//  6. start tied high, res_ready tied high, OR model -> back-to-back sweeps.
//     res_valid is a 1-cycle pulse every 19 cycles, code 1 each time.

Source files
------------

// File: rtl/calc_pkg.sv
// Shared gate-block definitions: function codes, truth tables, identifier FSM states
// and the result payload.
package calc_pkg;

   localparam logic [2:0] GATE_AND  = 3'd0;
   localparam logic [2:0] GATE_OR   = 3'd1;
   localparam logic [2:0] GATE_XOR  = 3'd2;
   localparam logic [2:0] GATE_NAND = 3'd3;
   localparam logic [2:0] GATE_NOR  = 3'd4;
   localparam logic [2:0] GATE_XNOR = 3'd5;
   localparam logic [2:0] GATE_NOT  = 3'd6;
   localparam logic [2:0] GATE_BUF  = 3'd7;

   // Truth tables: bit k is the gate output for {in1,in2} = k
   localparam logic [3:0] TT_AND  = 4'b1000;
   localparam logic [3:0] TT_OR   = 4'b1110;
   localparam logic [3:0] TT_XOR  = 4'b0110;
   localparam logic [3:0] TT_NAND = 4'b0111;
   localparam logic [3:0] TT_NOR  = 4'b0001;
   localparam logic [3:0] TT_XNOR = 4'b1001;
   localparam logic [3:0] TT_NOT  = 4'b0011;
   localparam logic [3:0] TT_BUF  = 4'b1100;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      DRIVE  = 2'd1,
      DECIDE = 2'd2,
      DONE   = 2'd3
   } gate_state_t;

   typedef struct packed {
      logic [3:0] tt;
      logic [2:0] code;
      logic       unknown;
   } gate_result_t;

endpackage

// File: rtl/sync_ff.sv
// Resettable multi-flop bit synchronizer for a signal asynchronous to clk.
module sync_ff #(
   parameter int unsigned STAGES = 2
) (
   input  logic clk,
   input  logic rst_n,
   input  logic d_i,
   output logic q_o
);

   logic [STAGES-1:0] sync_q;

   // Shift in at the LSB; the cast drops the oldest bit off the top
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) sync_q <= '0;
      else        sync_q <= STAGES'({sync_q, d_i});
   end

   assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/gate_identifier.sv
// Drives all four input vectors into an unknown 2-input gate, captures its truth table
// and reports the decoded gate function over a valid/ready handshake.
module gate_identifier
   import calc_pkg::*;
#(
   parameter int unsigned SETTLE_CYCLES = 4,
   parameter int unsigned SYNC_STAGES   = 2
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       start,
   output logic       busy,
   output logic       drv_in1,
   output logic       drv_in2,
   input  logic       dut_y,
   output logic       res_valid,
   input  logic       res_ready,
   output logic [2:0] res_code,
   output logic       res_unknown,
   output logic [3:0] res_tt
);

   localparam int unsigned CNT_W = $clog2(SETTLE_CYCLES + 1);

   gate_state_t  state_q, state_d;
   logic [1:0]   k_q, k_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [3:0]   tt_q, tt_d;
   logic [1:0]   drv_q, drv_d;
   logic         busy_q, busy_d;
   logic         res_valid_q, res_valid_d;
   gate_result_t res_q, res_d;
   gate_result_t dec;
   logic         dut_y_sync;

   sync_ff #(.STAGES(SYNC_STAGES)) u_sync (
      .clk   (clk),
      .rst_n (rst_n),
      .d_i   (dut_y),
      .q_o   (dut_y_sync)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         k_q         <= '0;
         cnt_q       <= '0;
         tt_q        <= '0;
         drv_q       <= '0;
         busy_q      <= 1'b0;
         res_valid_q <= 1'b0;
         res_q       <= '0;
      end else begin
         state_q     <= state_d;
         k_q         <= k_d;
         cnt_q       <= cnt_d;
         tt_q        <= tt_d;
         drv_q       <= drv_d;
         busy_q      <= busy_d;
         res_valid_q <= res_valid_d;
         res_q       <= res_d;
      end
   end

   // Truth table to gate code
   always_comb begin
      dec    = '0;
      dec.tt = tt_q;
      case (tt_q)
         TT_AND:  dec.code = GATE_AND;
         TT_OR:   dec.code = GATE_OR;
         TT_XOR:  dec.code = GATE_XOR;
         TT_NAND: dec.code = GATE_NAND;
         TT_NOR:  dec.code = GATE_NOR;
         TT_XNOR: dec.code = GATE_XNOR;
         TT_NOT:  dec.code = GATE_NOT;
         TT_BUF:  dec.code = GATE_BUF;
         default: dec.unknown = 1'b1;
      endcase
   end

   always_comb begin
      state_d     = state_q;
      k_d         = k_q;
      cnt_d       = cnt_q;
      tt_d        = tt_q;
      res_valid_d = res_valid_q;
      res_d       = res_q;

      case (state_q)
         IDLE: begin
            if (start) begin
               state_d = DRIVE;
               k_d     = '0;
               cnt_d   = '0;
            end
         end
         DRIVE: begin
            cnt_d = cnt_q + CNT_W'(1);
            // Vector has settled through the gate and the synchronizer: capture it
            if (cnt_q == CNT_W'(SETTLE_CYCLES - 1)) begin
               tt_d[k_q] = dut_y_sync;
               cnt_d     = '0;
               if (k_q == 2'd3) state_d = DECIDE;
               else             k_d     = k_q + 2'd1;
            end
         end
         DECIDE: begin
            res_d       = dec;
            res_valid_d = 1'b1;
            state_d     = DONE;
         end
         DONE: begin
            if (res_valid_q && res_ready) begin
               res_valid_d = 1'b0;
               state_d     = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase

      // Outputs follow the next state so they are exact registered copies
      drv_d  = (state_d == DRIVE) ? k_d : 2'b00;
      busy_d = (state_d == DRIVE) || (state_d == DECIDE);
   end

   assign busy        = busy_q;
   assign drv_in1     = drv_q[1];
   assign drv_in2     = drv_q[0];
   assign res_valid   = res_valid_q;
   assign res_code    = res_q.code;
   assign res_unknown = res_q.unknown;
   assign res_tt      = res_q.tt;

endmodule

// File: tb/tb_gate_identifier.sv
// Directed bench for gate_identifier: behavioural gate model on drv_*, scoreboard of
// expected results checked when res_valid appears.
module tb_gate_identifier;

   logic       clk;
   logic       rst_n;
   logic       start;
   logic       busy;
   logic       drv_in1;
   logic       drv_in2;
   logic       dut_y = 1'b0;
   logic       res_valid;
   logic       res_ready;
   logic [2:0] res_code;
   logic       res_unknown;
   logic [3:0] res_tt;

   typedef struct {
      logic [3:0] tt;
      logic [2:0] code;
      logic       unk;
   } exp_t;

   exp_t sb[$];
   int   gmode = 0;
   int   cyc   = 0;
   int   n_vec = 0;
   int   n_err = 0;

   gate_identifier #(.SETTLE_CYCLES(4), .SYNC_STAGES(2)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .start       (start),
      .busy        (busy),
      .drv_in1     (drv_in1),
      .drv_in2     (drv_in2),
      .dut_y       (dut_y),
      .res_valid   (res_valid),
      .res_ready   (res_ready),
      .res_code    (res_code),
      .res_unknown (res_unknown),
      .res_tt      (res_tt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Modes 0..7 are the gate-block functions; 8 = constant 1, 9 = buffer of in2
   function automatic logic gate_f(input int m, input logic a, input logic b);
      case (m)
         0: return a & b;
         1: return a | b;
         2: return a ^ b;
         3: return ~(a & b);
         4: return ~(a | b);
         5: return ~(a ^ b);
         6: return ~a;
         7: return a;
         8: return 1'b1;
         9: return b;
         default: return 1'b0;
      endcase
   endfunction

   always @(posedge clk) dut_y <= gate_f(gmode, drv_in1, drv_in2);

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
      cyc++;
   endtask

   task automatic push_exp(input int mode);
      exp_t e;
      logic [1:0] kv;
      for (int k = 0; k < 4; k++) begin
         kv = 2'(k);
         e.tt[k] = gate_f(mode, kv[1], kv[0]);
      end
      e.code = (mode < 8) ? 3'(mode) : 3'd0;
      e.unk  = (mode >= 8);
      sb.push_back(e);
   endtask

   task automatic start_sweep(input int mode);
      push_exp(mode);
      gmode = mode;
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   task automatic wait_valid();
      int n;
      n = 0;
      while (res_valid !== 1'b1 && n < 100) begin
         tick();
         n++;
      end
   endtask

   task automatic pop_check(input string tag);
      exp_t e;
      if (sb.size() == 0) begin
         chk({tag, "_sb_nonempty"}, 32'd0, 32'd1);
      end else begin
         e = sb.pop_front();
         chk({tag, "_valid"}, 32'(res_valid), 32'd1);
         chk({tag, "_tt"}, 32'(res_tt), 32'(e.tt));
         chk({tag, "_code"}, 32'(res_code), 32'(e.code));
         chk({tag, "_unknown"}, 32'(res_unknown), 32'(e.unk));
      end
   endtask

   task automatic do_sweep(input int mode, input string tag);
      int c0;
      start_sweep(mode);
      c0 = cyc;
      wait_valid();
      chk({tag, "_latency"}, 32'(cyc - c0), 32'd17);
      pop_check(tag);
      res_ready = 1'b1;
      tick();
      chk({tag, "_valid_drop"}, 32'(res_valid), 32'd0);
      res_ready = 1'b0;
      tick();
   endtask

   initial begin
      exp_t e;
      int   c0;
      int   tprev;

      rst_n     = 1'b0;
      start     = 1'b0;
      res_ready = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("reset_outputs", 32'({busy, drv_in1, drv_in2, res_valid, res_code, res_unknown, res_tt}), 32'd0);
      rst_n = 1'b1;
      tick();

      // XOR sweep with drive sequence and timing
      start_sweep(2);
      c0 = cyc;
      chk("t1_drv_00", 32'({drv_in1, drv_in2}), 32'd0);
      chk("t1_busy", 32'(busy), 32'd1);
      repeat (4) tick();
      chk("t1_drv_01", 32'({drv_in1, drv_in2}), 32'd1);
      repeat (4) tick();
      chk("t1_drv_10", 32'({drv_in1, drv_in2}), 32'd2);
      repeat (4) tick();
      chk("t1_drv_11", 32'({drv_in1, drv_in2}), 32'd3);
      repeat (4) tick();
      chk("t1_decide_drv", 32'({drv_in1, drv_in2}), 32'd0);
      chk("t1_decide_busy", 32'(busy), 32'd1);
      chk("t1_decide_valid", 32'(res_valid), 32'd0);
      tick();
      chk("t1_latency", 32'(cyc - c0), 32'd17);
      chk("t1_tt_literal", 32'(res_tt), 32'b0110);
      chk("t1_done_busy", 32'(busy), 32'd0);
      pop_check("t1");
      res_ready = 1'b1;
      tick();
      chk("t1_valid_drop", 32'(res_valid), 32'd0);
      chk("t1_tt_kept", 32'(res_tt), 32'b0110);
      res_ready = 1'b0;
      tick();

      // All eight functions, then two tables that decode to nothing
      for (int m = 0; m < 8; m++) do_sweep(m, $sformatf("t2_m%0d", m));
      do_sweep(8, "t3_const1");
      do_sweep(9, "t3_buf_in2");

      // NAND with stalled consumer and start pulses that must be ignored
      start_sweep(3);
      c0 = cyc;
      repeat (5) tick();
      start = 1'b1;
      tick();
      start = 1'b0;
      wait_valid();
      chk("t4_latency", 32'(cyc - c0), 32'd17);
      if (sb.size() != 0) begin
         e = sb[0];
         for (int i = 0; i < 10; i++) begin
            if (i == 3) start = 1'b1;
            if (i == 4) start = 1'b0;
            chk("t4_hold_valid", 32'(res_valid), 32'd1);
            chk("t4_hold_result", 32'({res_tt, res_code, res_unknown}), 32'({e.tt, e.code, e.unk}));
            tick();
         end
      end
      pop_check("t4");
      res_ready = 1'b1;
      tick();
      chk("t4_valid_drop", 32'(res_valid), 32'd0);
      res_ready = 1'b0;
      repeat (3) tick();
      chk("t4_no_queued_start", 32'(busy), 32'd0);

      // Reset in the middle of a sweep
      start_sweep(2);
      repeat (8) tick();
      #2;
      rst_n = 1'b0;
      #1;
      chk("t5_async_reset", 32'({busy, drv_in1, drv_in2, res_valid, res_code, res_unknown, res_tt}), 32'd0);
      sb.delete();
      tick();
      tick();
      rst_n = 1'b1;
      tick();
      chk("t5_after_release", 32'({busy, res_valid}), 32'd0);
      do_sweep(0, "t5_and");

      // Back-to-back sweeps with start and res_ready tied high
      for (int p = 0; p < 3; p++) push_exp(1);
      gmode     = 1;
      res_ready = 1'b1;
      start     = 1'b1;
      tick();
      c0 = cyc;
      wait_valid();
      chk("t6_latency", 32'(cyc - c0), 32'd17);
      pop_check("t6_p0");
      tprev = cyc;
      tick();
      chk("t6_pulse0", 32'(res_valid), 32'd0);
      for (int p = 1; p < 3; p++) begin
         wait_valid();
         chk("t6_period", 32'(cyc - tprev), 32'd19);
         pop_check("t6_pn");
         tprev = cyc;
         if (p == 2) start = 1'b0;
         tick();
         chk("t6_pulse", 32'(res_valid), 32'd0);
      end
      res_ready = 1'b0;
      repeat (3) tick();
      chk("t6_idle", 32'(busy), 32'd0);
      chk("t6_sb_empty", 32'(sb.size()), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
